rgb_hue_sequencer: RTL and testbench

// - Sequences three PWM duty values (R, G, B) around the six-segment HSV colour wheel.
// - Replaces the single-channel ramp as the duty source for three pwm instances.

---
 rtl/rgb_hue_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rgb_hue_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_hue_sequencer.sv
// Steps three PWM duty values (R, G, B) around the six-segment HSV wheel,
// committing each step only at a PWM frame start. Optional HUE_GAMMA_EN squares the outputs.
module rgb_hue_sequencer #(
  parameter int PWM_MAX     = 1200,
  parameter int STEP        = 12,
  parameter int STEP_CYCLES = 20000,
  localparam int DUTY_W     = $clog2(PWM_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [2:0]        seg,
  output logic              seg_done,
  output logic              busy
);

  localparam int PRESC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);
  localparam logic [DUTY_W:0]    MAX_X      = (DUTY_W + 1)'(PWM_MAX);
  localparam logic [DUTY_W:0]    STEP_X     = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0]  MAX_D      = DUTY_W'(PWM_MAX);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [DUTY_W-1:0]    lin_reg  [3];
  logic [DUTY_W-1:0]    lin_next [3];
  logic [2:0]           seg_reg, seg_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic                 pending_reg, pending_next;
  logic                 seg_done_reg, seg_done_next;

  logic                 tick;
  logic [1:0]           ramp_ch;
  logic                 ramp_up;
  logic [DUTY_W:0]      ramp_cur;
  logic [DUTY_W:0]      ramp_val;
  logic                 ramp_end;

  assign tick = (presc_reg == PRESC_LAST);

  // Which channel ramps in the current segment, and in which direction.
  always_comb begin
    ramp_ch = 2'd1;
    ramp_up = 1'b1;
    case (seg_reg)
      3'd0:    begin ramp_ch = 2'd1; ramp_up = 1'b1; end
      3'd1:    begin ramp_ch = 2'd0; ramp_up = 1'b0; end
      3'd2:    begin ramp_ch = 2'd2; ramp_up = 1'b1; end
      3'd3:    begin ramp_ch = 2'd1; ramp_up = 1'b0; end
      3'd4:    begin ramp_ch = 2'd0; ramp_up = 1'b1; end
      3'd5:    begin ramp_ch = 2'd2; ramp_up = 1'b0; end
      default: begin ramp_ch = 2'd1; ramp_up = 1'b1; end
    endcase
    ramp_cur = {1'b0, lin_reg[ramp_ch]};
    ramp_val = ramp_cur;
    ramp_end = 1'b0;
    if (ramp_up) begin
      if (ramp_cur + STEP_X >= MAX_X) begin
        ramp_val = MAX_X;
        ramp_end = 1'b1;
      end else begin
        ramp_val = ramp_cur + STEP_X;
      end
    end else begin
      if (ramp_cur <= STEP_X) begin
        ramp_val = '0;
        ramp_end = 1'b1;
      end else begin
        ramp_val = ramp_cur - STEP_X;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    lin_next      = lin_reg;
    seg_next      = seg_reg;
    presc_next    = presc_reg;
    pending_next  = pending_reg;
    seg_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next  = RUN;
          lin_next[0] = MAX_D;
          lin_next[1] = '0;
          lin_next[2] = '0;
          seg_next    = 3'd0;
        end
      end
      RUN: begin
        presc_next   = tick ? '0 : presc_reg + 1'b1;
        pending_next = pending_reg | tick;
        // A tick landing on the frame start commits immediately.
        if ((pending_reg | tick) && period_start) begin
          pending_next      = 1'b0;
          lin_next[ramp_ch] = ramp_val[DUTY_W-1:0];
          if (ramp_end) begin
            seg_next      = (seg_reg == 3'd5) ? 3'd0 : seg_reg + 3'd1;
            seg_done_next = 1'b1;
          end
        end
        if (!run) state_next = HOLD;
      end
      HOLD: begin
        if (run) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      for (int i = 0; i < 3; i++) lin_reg[i] <= '0;
      seg_reg      <= 3'd0;
      presc_reg    <= '0;
      pending_reg  <= 1'b0;
      seg_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lin_reg      <= lin_next;
      seg_reg      <= seg_next;
      presc_reg    <= presc_next;
      pending_reg  <= pending_next;
      seg_done_reg <= seg_done_next;
    end
  end

  logic [DUTY_W-1:0] duty_out [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
`ifdef HUE_GAMMA_EN
      logic [2*DUTY_W-1:0] sq;
      logic [DUTY_W-1:0]   gamma_reg;
      assign sq = lin_reg[gi] * lin_reg[gi];
      // Quotient never exceeds PWM_MAX, so it fits the duty width.
      always_ff @(posedge clk) begin
        if (!rst_n) gamma_reg <= '0;
        else        gamma_reg <= DUTY_W'(sq / (2 * DUTY_W)'(PWM_MAX));
      end
      assign duty_out[gi] = gamma_reg;
`else
      assign duty_out[gi] = lin_reg[gi];
`endif
    end
  endgenerate

  assign duty_r   = duty_out[0];
  assign duty_g   = duty_out[1];
  assign duty_b   = duty_out[2];
  assign seg      = seg_reg;
  assign seg_done = seg_done_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Randomised bench for rgb_hue_sequencer: two instances (STEP=5 and STEP=4)
// checked every cycle against a wheel-table reference model, plus literal checkpoints.
module tb_rgb_hue_sequencer;

  localparam int MAXV = 15;
  localparam int SC   = 4;
  localparam int STEPS [2] = '{5, 4};
  localparam int RAMP_CH [6] = '{1, 0, 2, 1, 0, 2};
  localparam int RAMP_UP [6] = '{1, 0, 1, 0, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic period_start = 1'b0;

  logic [3:0] act_r [2];
  logic [3:0] act_g [2];
  logic [3:0] act_b [2];
  logic [2:0] act_seg [2];
  logic       act_done [2];
  logic       act_busy [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rgb_hue_sequencer #(.PWM_MAX(MAXV), .STEP(5), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .period_start(period_start),
    .duty_r(act_r[0]), .duty_g(act_g[0]), .duty_b(act_b[0]),
    .seg(act_seg[0]), .seg_done(act_done[0]), .busy(act_busy[0])
  );

  rgb_hue_sequencer #(.PWM_MAX(MAXV), .STEP(4), .STEP_CYCLES(SC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(run), .period_start(period_start),
    .duty_r(act_r[1]), .duty_g(act_g[1]), .duty_b(act_b[1]),
    .seg(act_seg[1]), .seg_done(act_done[1]), .busy(act_busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=running 2=held.
  int m_mode [2];
  int m_lin [2][3];
  int m_gam [2][3];
  int m_seg [2];
  int m_presc [2];
  bit m_pend [2];
  bit m_done [2];
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) m_gam[k][c] = rst_n ? (m_lin[k][c] * m_lin[k][c]) / MAXV : 0;
      m_done[k] = 1'b0;
      if (!rst_n) begin
        m_mode[k] = 0; m_seg[k] = 0; m_presc[k] = 0; m_pend[k] = 1'b0;
        for (int c = 0; c < 3; c++) m_lin[k][c] = 0;
      end else if (m_mode[k] == 0) begin
        if (run) begin
          m_mode[k] = 1; m_seg[k] = 0;
          m_lin[k][0] = MAXV; m_lin[k][1] = 0; m_lin[k][2] = 0;
        end
      end else if (m_mode[k] == 1) begin
        if (m_presc[k] == SC - 1) begin
          m_presc[k] = 0;
          m_pend[k] = 1'b1;
        end else begin
          m_presc[k]++;
        end
        if (m_pend[k] && period_start) begin
          int ch, v;
          bit at_end;
          m_pend[k] = 1'b0;
          ch = RAMP_CH[m_seg[k]];
          v = RAMP_UP[m_seg[k]] ? m_lin[k][ch] + STEPS[k] : m_lin[k][ch] - STEPS[k];
          at_end = (v >= MAXV) || (v <= 0);
          if (v > MAXV) v = MAXV;
          if (v < 0) v = 0;
          m_lin[k][ch] = v;
          if (at_end) begin
            m_seg[k] = (m_seg[k] + 1) % 6;
            m_done[k] = 1'b1;
          end
        end
        if (!run) m_mode[k] = 2;
      end else begin
        if (run) m_mode[k] = 1;
      end
    end
    model_valid = 1'b1;
  end

  function automatic int exp_duty(input int k, input int c);
`ifdef HUE_GAMMA_EN
    return m_gam[k][c];
`else
    return m_lin[k][c];
`endif
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d_duty_r", k), 32'(act_r[k]), 32'(exp_duty(k, 0)));
        chk($sformatf("u%0d_duty_g", k), 32'(act_g[k]), 32'(exp_duty(k, 1)));
        chk($sformatf("u%0d_duty_b", k), 32'(act_b[k]), 32'(exp_duty(k, 2)));
        chk($sformatf("u%0d_seg", k), 32'(act_seg[k]), 32'(m_seg[k]));
        chk($sformatf("u%0d_seg_done", k), 32'(act_done[k]), 32'(m_done[k]));
        chk($sformatf("u%0d_busy", k), 32'(act_busy[k]), 32'(m_mode[k] != 0));
      end
    end
  end

  task automatic drive(input logic r_n, input logic run_v, input logic ps_v);
    rst_n = r_n;
    run = run_v;
    period_start = ps_v;
    @(posedge clk);
    #1;
  endtask

  int done_cnt;
  int prev_sat_g;
  int guard;

  initial begin
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
    chk("reset_busy", 32'(act_busy[0]), 32'd0);
    chk("reset_duty_r", 32'(act_r[0]), 32'd0);
    chk("reset_seg", 32'(act_seg[0]), 32'd0);

    drive(1'b1, 1'b1, 1'b0);
    chk("start_busy", 32'(act_busy[0]), 32'd1);
`ifndef HUE_GAMMA_EN
    chk("start_duty_r", 32'(act_r[0]), 32'd15);
    chk("start_duty_g", 32'(act_g[0]), 32'd0);
`endif

    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
`ifndef HUE_GAMMA_EN
    chk("gated_duty_g", 32'(act_g[0]), 32'd0);
`endif
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
`ifndef HUE_GAMMA_EN
    chk("one_step_duty_g", 32'(act_g[0]), 32'd5);
    chk("one_step_sat_g", 32'(act_g[1]), 32'd4);
`endif

    done_cnt = 0;
    prev_sat_g = int'(act_g[1]);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      if (act_done[0]) done_cnt++;
`ifndef HUE_GAMMA_EN
      if (act_g[1] == 4'd15 && prev_sat_g != 15 && act_seg[1] == 3'd1) begin
        chk("sat_prev_g", 32'(prev_sat_g), 32'd12);
      end
`endif
      prev_sat_g = int'(act_g[1]);
    end
    chk("wheel_done_ge6", 32'(done_cnt >= 6), 32'd1);

`ifndef HUE_GAMMA_EN
    guard = 0;
    while (!(act_seg[0] == 3'd2 && act_b[0] == 4'd10) && guard < 300) begin
      drive(1'b1, 1'b1, 1'b1);
      guard++;
    end
    chk("reach_seg2_b10", 32'(guard < 300), 32'd1);
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b0, 1'b1);
    chk("hold_busy", 32'(act_busy[0]), 32'd1);
    chk("hold_duty_b", 32'(act_b[0]), 32'd10);
    guard = 0;
    while (act_b[0] == 4'd10 && guard < 20) begin
      drive(1'b1, 1'b1, 1'b1);
      guard++;
    end
    chk("resume_duty_b", 32'(act_b[0]), 32'd15);
`endif

    for (int i = 0; i < 4000; i++) begin
      drive(logic'($urandom_range(0, 299) != 0),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
